// File: rtl/multiword_add_seq.sv
// Multi-precision add/subtract sequencer: one N-bit adder slice reused over
// WORDS cycles, least-significant chunk first, with the carry registered between chunks.
module multiword_add_seq #(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sub,
  input  logic                 cin,
  input  logic [N*WORDS-1:0]   a,
  input  logic [N*WORDS-1:0]   b,
  output logic                 busy,
  output logic                 done,
  output logic [N*WORDS-1:0]   sum,
  output logic                 cout,
  output logic                 overflow
);

  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 2) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [W-1:0]    opa;
  logic [W-1:0]    opb;
  logic [W-N-1:0]  wsum;
  logic            carry;
  logic [IW-1:0]   idx;

  logic [N:0]      slice;
  logic            cmsb;
  logic [W-1:0]    cat;

  // Operands shift right and the working sum shifts in from the top, so the
  // active chunk is always at bit 0 and no variable part-select is needed.
  always_comb begin
    slice = {1'b0, opa[N-1:0]} + {1'b0, opb[N-1:0]} + {{N{1'b0}}, carry};
    cmsb  = slice[N-1] ^ opa[N-1] ^ opb[N-1];
    cat   = {slice[N-1:0], wsum};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      opa      <= '0;
      opb      <= '0;
      wsum     <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub | cin;
            idx   <= '0;
            wsum  <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          opa   <= {{N{1'b0}}, opa[W-1:N]};
          opb   <= {{N{1'b0}}, opb[W-1:N]};
          wsum  <= cat[W-1:N];
          carry <= slice[N];
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            idx      <= '0;
            sum      <= cat;
            cout     <= slice[N];
            overflow <= slice[N] ^ cmsb;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Bench for multiword_add_seq: full-width behavioural model compared every
// cycle, plus directed vectors with hand-computed results and timing.
module tb_multiword_add_seq;

  localparam int N     = 4;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          sub;
  logic          cin;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [W-1:0]  sum;
  logic          cout;
  logic          overflow;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;
  logic [W-1:0] prev_sum = '0;

  multiword_add_seq #(.N(N), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin),
    .a(a), .b(b), .busy(busy), .done(done), .sum(sum), .cout(cout),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Full-width reference: {overflow, cout, sum} from plain integer arithmetic.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s, input logic ci);
    longint ux = longint'(x);
    longint uy = longint'(y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint smax = (longint'(1) << (W - 1)) - 1;
    longint smin = -(longint'(1) << (W - 1));
    longint ures;
    longint sres;
    logic   c;
    logic   o;
    if (s) begin
      ures = ux - uy;
      sres = sx - sy;
      c    = (ux >= uy);
    end else begin
      ures = ux + uy + longint'(ci);
      sres = sx + sy + longint'(ci);
      c    = (ures >= (longint'(1) << W));
    end
    o = (sres > smax) || (sres < smin);
    return {o, c, ures[W-1:0]};
  endfunction

  logic          m_busy, m_done, m_cout, m_ovf;
  logic [W-1:0]  m_sum;
  logic [W+1:0]  m_pend;
  int            m_timer;

  // Model: an accepted request occupies WORDS+2 cycles; results appear after WORDS edges.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_cout  <= 1'b0;
      m_ovf   <= 1'b0;
      m_sum   <= '0;
      m_pend  <= '0;
      m_timer <= 0;
    end else if (m_timer == 0) begin
      if (start) begin
        m_pend  <= ref_op(a, b, sub, cin);
        m_timer <= WORDS + 1;
        m_busy  <= 1'b1;
      end
    end else begin
      m_timer <= m_timer - 1;
      if (m_timer == 2) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        {m_ovf, m_cout, m_sum} <= m_pend;
      end else if (m_timer == 1) begin
        m_done <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc busy", 32'(busy), 32'(m_busy));
      check("cyc done", 32'(done), 32'(m_done));
      check("cyc sum", 32'(sum), 32'(m_sum));
      check("cyc cout", 32'(cout), 32'(m_cout));
      check("cyc overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tbv,
                        input logic ts, input logic tc, input logic [W-1:0] es,
                        input logic ec, input logic eo, input bit scramble);
    int busy_cnt = 0;
    int done_at  = 0;
    @(negedge clk);
    a = ta; b = tbv; sub = ts; cin = tc; start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 12 && done_at == 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (scramble && cyc == 2) begin
        a = ~ta; b = 16'h5A5A; sub = ~ts; cin = ~tc;
      end
      if (cyc == 3) check({nm, " held prev sum"}, 32'(sum), 32'(prev_sum));
      if (busy) busy_cnt++;
      if (done) done_at = cyc;
    end
    check({nm, " busy cycles"}, 32'(busy_cnt), 32'(WORDS));
    check({nm, " done latency"}, 32'(done_at), 32'(WORDS + 1));
    check({nm, " sum"}, 32'(sum), 32'(es));
    check({nm, " cout"}, 32'(cout), 32'(ec));
    check({nm, " overflow"}, 32'(overflow), 32'(eo));
    check({nm, " model sum"}, 32'(m_sum), 32'(es));
    check({nm, " model flags"}, 32'({m_ovf, m_cout}), 32'({eo, ec}));
    @(negedge clk);
    check({nm, " done pulse width"}, 32'(done), 32'd0);
    prev_sum = es;
  endtask

  initial begin
    int rises[$];
    logic pb;
    bit idle_ok;
    rst_n = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    #2 rst_n = 1'b0;
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset sum", 32'(sum), 32'd0);
    check("reset flags", 32'({overflow, cout}), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    chk_en = 1;

    run_op("add 00FF+0001", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle hold sum", 32'(sum), 32'h0100);
    end
    run_op("add 7FFF+0001", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
    run_op("add FFFF+0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    run_op("add 0+0+cin", 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 0);
    run_op("sub 5-7", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
    run_op("sub 8000-1", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 0);
    run_op("sub scrambled", 16'h1234, 16'h0234, 1'b1, 1'b0, 16'h1000, 1'b1, 1'b0, 1);

    // Continuous start: acceptances must be WORDS+2 cycles apart.
    @(negedge clk);
    a = 16'h1000; b = 16'h0234; sub = 1'b0; cin = 1'b0; start = 1'b1;
    pb = busy;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy && !pb) rises.push_back(i);
      pb = busy;
    end
    start = 1'b0;
    check("continuous accept count", 32'(rises.size()), 32'd4);
    for (int i = 0; i < rises.size(); i++)
      check("continuous accept cycle", 32'(rises[i]), 32'(i * (WORDS + 2)));
    idle_ok = 0;
    for (int i = 0; i < 20 && !idle_ok; i++) begin
      @(negedge clk);
      if (!busy && !done) idle_ok = 1;
    end
    check("continuous drain", 32'(idle_ok), 32'd1);
    check("continuous sum", 32'(sum), 32'h1234);

    // Reset after two chunks of a carry-propagating add.
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun reset busy", 32'(busy), 32'd0);
    check("midrun reset done", 32'(done), 32'd0);
    check("midrun reset sum", 32'(sum), 32'd0);
    check("midrun reset flags", 32'({overflow, cout}), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    prev_sum = '0;
    run_op("add after reset", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 0);

    repeat (2) @(negedge clk);
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiword_add_seq.md
Name: multiword_add_seq

Overview:
- Multi-precision add/subtract sequencer: one N-bit ripple adder slice, reused over WORDS consecutive cycles, least-significant chunk first.
- Carry is registered between chunks, giving an N*WORDS-bit result with carry-out and signed overflow.
- Sits between a requesting controller (start/done handshake) and the shared adder slice, so wide arithmetic costs one N-bit adder instead of a full-width one.

Parameters:
- N, 4, chunk width in bits (width of the shared adder slice).
- WORDS, 4, number of chunks per operation; total width W = N*WORDS; WORDS >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; accepted only on a rising edge in IDLE.
- sub  input  1  0 = add, 1 = subtract (a - b); sampled with start.
- cin  input  1  carry-in for add; ignored when sub=1.
- a  input  W  operand A; sampled with start.
- b  input  W  operand B; sampled with start.
- busy  output  1  high while chunks are being processed (RUN state).
- done  output  1  one-cycle pulse; results valid from this cycle.
- sum  output  W  result, registered.
- cout  output  1  carry out of bit W-1.
- overflow  output  1  two's-complement overflow: carry into bit W-1 XOR carry out of bit W-1.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, sum=0, cout=0, overflow=0; internal index, carry, operand and working registers cleared. Takes effect immediately, including mid-operation; the partial result is discarded and not reported.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at an edge:
  - Latch a into opA.
  - Latch b into opB, or ~b if sub=1.
  - carry <= (sub ? 1 : cin); idx <= 0; next state RUN.
  - start=0: remain in IDLE.
- RUN, each edge:
  - Chunk k = idx.
  - {c, s} = opA[kN+N-1:kN] + opB[kN+N-1:kN] + carry.
  - Working sum chunk k <= s; carry <= c; idx <= idx+1.
  - Record carry into chunk MSB (bit N-1) every cycle; only the last chunk's value is used.
  - When idx == WORDS-1: sum <= working result with the final chunk, cout <= c, overflow <= c ^ (carry into bit N-1 of final chunk); next state DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Latency: start sampled at edge 0; chunks processed at edges 1..WORDS; done high for the cycle after edge WORDS; back in IDLE after edge WORDS+1.
  - busy=1 from after edge 0 until after edge WORDS (WORDS cycles).
  - Minimum start-to-start spacing: WORDS+2 cycles.
- start while busy or in DONE: ignored, not queued. Operand or sub changes during RUN have no effect.
- sum/cout/overflow change only at the RUN->DONE edge and hold until the next completion or reset. They never show partial chunks.
- Arithmetic is modulo 2^W.
  - Subtract: cout=1 means no borrow (a >= b unsigned).
  - overflow per signed W-bit interpretation.
- idx width: clog2(WORDS), minimum 1 bit. No wrap beyond WORDS-1 is reachable.

Test Plan:
- Default N=4, WORDS=4 (W=16) for all scenarios.
- add 0x00FF + 0x0001, cin=0 -> sum=0x0100, cout=0, overflow=0; busy high 4 cycles; done pulses exactly 5 cycles after the start edge.
- add 0x7FFF + 0x0001 -> sum=0x8000, cout=0, overflow=1; add 0xFFFF + 0x0001 -> sum=0x0000, cout=1, overflow=0; add 0x0000 + 0x0000, cin=1 -> sum=0x0001.
- sub 0x0005 - 0x0007 -> sum=0xFFFE, cout=0, overflow=0; sub 0x8000 - 0x0001 -> sum=0x7FFF, cout=1, overflow=1.
- start asserted continuously for 20 cycles with constant operands -> new operation accepted only every 6 cycles.
  - Change operands during RUN -> result reflects the originally latched values.
- Reset handling:
  - rst_n low during RUN (after 2 chunks) -> immediately busy=0, done=0, sum=0.
  - Next start after release -> correct full result, no stale carry.
- Previous result (0x0100) held unchanged through idle cycles and through the next RUN, until that run's done.
